rtc_alarm_core: RTL

Parametrised BCD time-of-day counter with a validated set handshake, 12/24-hour display formatting and `NUM_ALARMS` hh:mm alarm channels. It generalises the free-running seconds clock in three ways: it derives its own 1 Hz tick from the system clock, it loads time only through a checked ready/valid port, and it raises sticky alarm flags. It sits between the board clock and the display/annunciator logic.

---
 rtl/clock_pkg.sv | 75 +++++++
 rtl/bcd_time_counter.sv | 74 +++++++
 rtl/rtc_alarm_core.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// ============================================================================
// Module      : clock_pkg
// Description : Shared BCD time types, set-FSM states and validation helpers
//               for the RTC alarm core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_pkg;

    typedef struct packed {
        logic [3:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } bcd_time_t;

    typedef struct packed {
        logic [3:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } bcd_hm_t;

    typedef struct packed {
        logic      pm;
        bcd_time_t t;
    } disp12_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        APPLY  = 2'd2,
        REJECT = 2'd3
    } set_state_e;

    function automatic logic hm_valid(input bcd_hm_t t);
        return ((t.h1 < 4'd2 && t.h0 <= 4'd9) || (t.h1 == 4'd2 && t.h0 <= 4'd3))
               && (t.m1 <= 4'd5) && (t.m0 <= 4'd9);
    endfunction

    function automatic logic time_valid(input bcd_time_t t);
        bcd_hm_t hm;
        hm.h1 = t.h1;
        hm.h0 = t.h0;
        hm.m1 = t.m1;
        hm.m0 = t.m0;
        return hm_valid(hm) && (t.s1 <= 4'd5) && (t.s0 <= 4'd9);
    endfunction

    // Input is assumed to be a legal 24-hour BCD time (it comes from the counter).
    function automatic disp12_t to_12h(input bcd_time_t t);
        disp12_t    d;
        logic [4:0] h24;
        logic [4:0] h12;
        h24  = 5'(t.h1) * 5'd10 + 5'(t.h0);
        d.t  = t;
        d.pm = (h24 >= 5'd12);
        if (h24 == 5'd0) begin
            h12 = 5'd12;
        end else if (h24 > 5'd12) begin
            h12 = h24 - 5'd12;
        end else begin
            h12 = h24;
        end
        d.t.h1 = (h12 >= 5'd10) ? 4'd1 : 4'd0;
        d.t.h0 = (h12 >= 5'd10) ? 4'(h12 - 5'd10) : 4'(h12);
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_time_counter.sv
// ============================================================================
// Module      : bcd_time_counter
// Description : Six-digit BCD hh:mm:ss cascade with load and increment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_time_counter
    import clock_pkg::*;
(
    input  logic      clk,
    input  logic      r_n,
    input  logic      inc,
    input  logic      load,
    input  bcd_time_t load_val,
    output bcd_time_t q,
    output bcd_time_t nxt,
    output logic      wrap
);

    bcd_time_t r_q;
    bcd_time_t w_nxt;

    always_comb begin
        w_nxt = r_q;
        if (r_q.s0 == 4'd9) begin
            w_nxt.s0 = 4'd0;
            if (r_q.s1 == 4'd5) begin
                w_nxt.s1 = 4'd0;
                if (r_q.m0 == 4'd9) begin
                    w_nxt.m0 = 4'd0;
                    if (r_q.m1 == 4'd5) begin
                        w_nxt.m1 = 4'd0;
                        if (r_q.h1 == 4'd2 && r_q.h0 == 4'd3) begin
                            w_nxt.h1 = 4'd0;
                            w_nxt.h0 = 4'd0;
                        end else if (r_q.h0 == 4'd9) begin
                            w_nxt.h0 = 4'd0;
                            w_nxt.h1 = r_q.h1 + 4'd1;
                        end else begin
                            w_nxt.h0 = r_q.h0 + 4'd1;
                        end
                    end else begin
                        w_nxt.m1 = r_q.m1 + 4'd1;
                    end
                end else begin
                    w_nxt.m0 = r_q.m0 + 4'd1;
                end
            end else begin
                w_nxt.s1 = r_q.s1 + 4'd1;
            end
        end else begin
            w_nxt.s0 = r_q.s0 + 4'd1;
        end
    end

    // A load takes priority over a concurrent increment.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= load_val;
        end else if (inc) begin
            r_q <= w_nxt;
        end
    end

    assign q    = r_q;
    assign nxt  = w_nxt;
    assign wrap = inc && !load && (r_q == 24'h235959);

endmodule

`default_nettype wire

// File: rtl/rtc_alarm_core.sv
// ============================================================================
// Module      : rtc_alarm_core
// Description : BCD time-of-day clock with 1 Hz prescaler, validated set
//               handshake, 12/24-hour display and sticky hh:mm alarms.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_alarm_core #(
    parameter  int TICK_DIV   = 1000,
    parameter  int NUM_ALARMS = 2,
    localparam int AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  r_n,
    input  logic                  hour_24,
    input  logic                  set_valid,
    output logic                  set_ready,
    input  logic [23:0]           set_time,
    input  logic                  alm_wr,
    input  logic [AW-1:0]         alm_idx,
    input  logic [15:0]           alm_time,
    input  logic                  alm_en,
    input  logic [NUM_ALARMS-1:0] alm_ack,
    output logic                  set_err,
    output logic [23:0]           time_bcd,
    output logic [23:0]           disp_bcd,
    output logic                  am,
    output logic                  pm,
    output logic                  sec_tick,
    output logic [NUM_ALARMS-1:0] alm_pend
);

    import clock_pkg::*;

    localparam int              c_presc_w   = $clog2(TICK_DIV);
    localparam [c_presc_w-1:0]  c_presc_max = c_presc_w'(TICK_DIV - 1);

    set_state_e           r_state;
    set_state_e           w_state_nxt;
    bcd_time_t            r_cap;
    logic [c_presc_w-1:0] r_presc;
    logic                 r_set_err;
    logic                 r_sec_tick;

    bcd_time_t w_time;
    bcd_time_t w_nxt;
    bcd_hm_t   w_nxt_hm;
    bcd_hm_t   w_alm_hm;
    disp12_t   w_12h;
    logic      w_tick;
    logic      w_apply;
    logic      w_inc;
    logic      w_wrap;
    logic      w_min_roll;
    logic      w_set_rej;
    logic      w_alm_ok;
    logic      w_alm_rej;

    // The load cycle owns the prescaler, so a coincident tick is dropped.
    assign w_tick  = (r_presc == c_presc_max);
    assign w_apply = (r_state == APPLY);
    assign w_inc   = w_tick && !w_apply;

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            r_presc <= '0;
        end else if (w_apply || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_presc_w'(1);
        end
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            r_state <= IDLE;
            r_cap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && set_valid) begin
                r_cap <= bcd_time_t'(set_time);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_set_rej   = 1'b0;
        case (r_state)
            IDLE: begin
                if (set_valid) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (time_valid(r_cap)) begin
                    w_state_nxt = APPLY;
                end else begin
                    w_state_nxt = REJECT;
                    w_set_rej   = 1'b1;
                end
            end
            APPLY:   w_state_nxt = IDLE;
            REJECT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign set_ready = (r_state == IDLE);

    bcd_time_counter u_counter (
        .clk      (clk),
        .r_n      (r_n),
        .inc      (w_inc),
        .load     (w_apply),
        .load_val (r_cap),
        .q        (w_time),
        .nxt      (w_nxt),
        .wrap     (w_wrap)
    );

    // Alarms compare against the value the tick is about to produce.
    assign w_min_roll = w_inc && (w_nxt.s1 == 4'd0) && (w_nxt.s0 == 4'd0);
    assign w_nxt_hm   = w_wrap ? '0 : {w_nxt.h1, w_nxt.h0, w_nxt.m1, w_nxt.m0};

    assign w_alm_hm  = bcd_hm_t'(alm_time);
    assign w_alm_ok  = alm_wr && (32'(alm_idx) < NUM_ALARMS) && hm_valid(w_alm_hm);
    assign w_alm_rej = alm_wr && !w_alm_ok;

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            r_set_err  <= 1'b0;
            r_sec_tick <= 1'b0;
        end else begin
            r_set_err  <= w_set_rej || w_alm_rej;
            r_sec_tick <= w_inc;
        end
    end

    assign set_err  = r_set_err;
    assign sec_tick = r_sec_tick;

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_alarm
        logic    r_en;
        logic    r_pend;
        bcd_hm_t r_hm;
        logic    w_hit;
        logic    w_match;

        assign w_hit   = w_alm_ok && (alm_idx == AW'(i));
        assign w_match = w_min_roll && r_en && (r_hm == w_nxt_hm);

        // A match uses the configuration held before any same-cycle write, and beats clears.
        always_ff @(posedge clk or negedge r_n) begin
            if (!r_n) begin
                r_en   <= 1'b0;
                r_hm   <= '0;
                r_pend <= 1'b0;
            end else begin
                if (w_hit) begin
                    r_en <= alm_en;
                    r_hm <= w_alm_hm;
                end
                if (w_match) begin
                    r_pend <= 1'b1;
                end else if (w_hit || alm_ack[i]) begin
                    r_pend <= 1'b0;
                end
            end
        end

        assign alm_pend[i] = r_pend;
    end

    assign w_12h    = to_12h(w_time);
    assign time_bcd = w_time;
    assign disp_bcd = hour_24 ? w_time : w_12h.t;
    assign am       = !hour_24 && !w_12h.pm;
    assign pm       = !hour_24 && w_12h.pm;

endmodule

`default_nettype wire
